// File: rtl/dc_cal_pkg.sv
// rtl/dc_cal_pkg.sv - shared types and constants for the DC-removal calibration sequencer
// Purpose : state encoding and default loop gains shared by dc_cal_ctrl and the
//           mult-add DC estimator datapath top.
// Ports   : none (package).
package dc_cal_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_TRACK   = 3'd3,
      ST_HOLD    = 3'd4
   } cal_state_e;

   localparam logic [15:0] K_FAST_DEF = 16'h0800;
   localparam logic [15:0] K_SLOW_DEF = 16'h0085;

endpackage

// File: rtl/dc_lock_det.sv
// rtl/dc_lock_det.sv - window-based settle detector for the DC estimate
// Purpose : every WIN_LEN enabled cycles compare dc_est with the previous
//           window's snapshot; LOCK_WINS consecutive small deltas assert locked.
// Ports   : clk, rst (sync, active low), en (count/evaluate this cycle),
//           clr (restart lock logic, wins over en), dc_est (signed estimate),
//           locked (registered settle indication).
module dc_lock_det import dc_cal_pkg::*; #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    WIN_LEN    = 1024,
   parameter logic [DATA_WIDTH-1:0] LOCK_TOL   = 16'd16,
   parameter int                    LOCK_WINS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] dc_est,
   output logic                  locked
);

   localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int SET_W = $clog2(LOCK_WINS + 1);

   logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
   logic [DATA_WIDTH-1:0] snap_q, snap_d;
   logic                  snap_vld_q, snap_vld_d;
   logic [SET_W-1:0]      settled_q, settled_d;
   logic                  locked_q, locked_d;

   logic                         wrap;
   logic signed [DATA_WIDTH:0]   diff;
   logic [DATA_WIDTH:0]          abs_diff;

   always_comb begin
      wrap = en && (win_cnt_q == WIN_W'(WIN_LEN - 1));
      // One extra bit so that e.g. 0x7FFF vs 0x8000 yields 65535, not 1.
      diff = $signed({dc_est[DATA_WIDTH-1], dc_est}) - $signed({snap_q[DATA_WIDTH-1], snap_q});
      abs_diff = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);

      win_cnt_d  = win_cnt_q;
      snap_d     = snap_q;
      snap_vld_d = snap_vld_q;
      settled_d  = settled_q;
      locked_d   = locked_q;

      if (clr) begin
         win_cnt_d  = '0;
         snap_d     = '0;
         snap_vld_d = 1'b0;
         settled_d  = '0;
         locked_d   = 1'b0;
      end else if (en) begin
         if (wrap) begin
            win_cnt_d  = '0;
            snap_d     = dc_est;
            snap_vld_d = 1'b1;
            // First wrap after a restart only seeds the snapshot.
            if (snap_vld_q) begin
               if (abs_diff <= {1'b0, LOCK_TOL}) begin
                  if (settled_q < SET_W'(LOCK_WINS))
                     settled_d = settled_q + SET_W'(1);
                  locked_d = (settled_d == SET_W'(LOCK_WINS));
               end else begin
                  settled_d = '0;
                  locked_d  = 1'b0;
               end
            end
         end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         win_cnt_q  <= '0;
         snap_q     <= '0;
         snap_vld_q <= 1'b0;
         settled_q  <= '0;
         locked_q   <= 1'b0;
      end else begin
         win_cnt_q  <= win_cnt_d;
         snap_q     <= snap_d;
         snap_vld_q <= snap_vld_d;
         settled_q  <= settled_d;
         locked_q   <= locked_d;
      end
   end

   assign locked = locked_q;

endmodule

// File: rtl/dc_cal_ctrl.sv
// rtl/dc_cal_ctrl.sv - clear/acquire/track sequencer for the mult-add DC-removal loop
// Purpose : drives accumulator clear/enable and loop gain, freezes the loop on
//           ADC over-range, reports lock once the DC estimate settles.
// Ports   : clk, rst (sync, active low), start (restart pulse), ad_din (ADC sample),
//           dc_est (datapath estimate) in; k_out, acc_sclr, acc_ena, state_o,
//           ovr_flag (sticky), locked out. All outputs registered.
module dc_cal_ctrl import dc_cal_pkg::*; #(
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] K_FAST      = K_FAST_DEF,
   parameter logic [DATA_WIDTH-1:0] K_SLOW      = K_SLOW_DEF,
   parameter int                    CLR_CYCLES  = 8,
   parameter int                    ACQ_CYCLES  = 4096,
   parameter int                    HOLD_CYCLES = 256,
   parameter logic [DATA_WIDTH-1:0] OVR_THRESH  = 16'd32000,
   parameter int                    WIN_LEN     = 1024,
   parameter logic [DATA_WIDTH-1:0] LOCK_TOL    = 16'd16,
   parameter int                    LOCK_WINS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] ad_din,
   input  logic [DATA_WIDTH-1:0] dc_est,
   output logic [DATA_WIDTH-1:0] k_out,
   output logic                  acc_sclr,
   output logic                  acc_ena,
   output logic [STATE_W-1:0]    state_o,
   output logic                  ovr_flag,
   output logic                  locked
);

   localparam int SEQ_MAX = (CLR_CYCLES > ACQ_CYCLES) ? CLR_CYCLES : ACQ_CYCLES;
   localparam int SEQ_W   = $clog2(SEQ_MAX) + 1;
   localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);

   cal_state_e            state_q, state_d;
   logic [SEQ_W-1:0]      seq_cnt_q, seq_cnt_d;
   logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic                  ovr_q, ovr_d;
   logic                  ovr_flag_q, ovr_flag_d;
   logic [DATA_WIDTH-1:0] k_out_q, k_out_d;
   logic                  acc_sclr_q, acc_sclr_d;
   logic                  acc_ena_q, acc_ena_d;

   logic signed [DATA_WIDTH-1:0] din_s, thr_s;
   logic                         lock_en, lock_clr;

   // Over-range compare; registered into ovr_q before it steers the FSM.
   always_comb begin
      din_s = $signed(ad_din);
      thr_s = $signed(OVR_THRESH);
      ovr_d = (din_s >= thr_s) || (din_s <= -thr_s);
   end

   always_comb begin
      state_d    = state_q;
      seq_cnt_d  = seq_cnt_q;
      hold_cnt_d = hold_cnt_q;
      ovr_flag_d = ovr_flag_q;

      if (start) begin
         state_d    = ST_CLEAR;
         seq_cnt_d  = '0;
         hold_cnt_d = '0;
         ovr_flag_d = 1'b0;
      end else begin
         if (ovr_q && (state_q != ST_IDLE))
            ovr_flag_d = 1'b1;
         case (state_q)
            ST_IDLE: ;
            ST_CLEAR: begin
               if (seq_cnt_q == SEQ_W'(CLR_CYCLES - 1)) begin
                  state_d   = ST_ACQUIRE;
                  seq_cnt_d = '0;
               end else begin
                  seq_cnt_d = seq_cnt_q + SEQ_W'(1);
               end
            end
            ST_ACQUIRE: begin
               if (seq_cnt_q == SEQ_W'(ACQ_CYCLES - 1)) begin
                  state_d   = ST_TRACK;
                  seq_cnt_d = '0;
               end else begin
                  seq_cnt_d = seq_cnt_q + SEQ_W'(1);
               end
            end
            ST_TRACK: begin
               if (ovr_q) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = HOLD_W'(HOLD_CYCLES);
               end
            end
            ST_HOLD: begin
               // Leave on the edge the count would reach 0, giving exactly
               // HOLD_CYCLES frozen cycles after the last over-range sample.
               if (ovr_q) begin
                  hold_cnt_d = HOLD_W'(HOLD_CYCLES);
               end else if (hold_cnt_q <= HOLD_W'(1)) begin
                  state_d    = ST_TRACK;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from the next state so they change on the entering edge.
   always_comb begin
      k_out_d    = K_SLOW;
      acc_sclr_d = 1'b0;
      acc_ena_d  = 1'b0;
      case (state_d)
         ST_IDLE:    acc_sclr_d = 1'b1;
         ST_CLEAR:   begin acc_sclr_d = 1'b1; acc_ena_d = 1'b1; k_out_d = K_FAST; end
         ST_ACQUIRE: begin acc_ena_d = 1'b1; k_out_d = K_FAST; end
         ST_TRACK:   acc_ena_d = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         seq_cnt_q  <= '0;
         hold_cnt_q <= '0;
         ovr_q      <= 1'b0;
         ovr_flag_q <= 1'b0;
         k_out_q    <= K_SLOW;
         acc_sclr_q <= 1'b1;
         acc_ena_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_cnt_q  <= seq_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         ovr_q      <= ovr_d;
         ovr_flag_q <= ovr_flag_d;
         k_out_q    <= k_out_d;
         acc_sclr_q <= acc_sclr_d;
         acc_ena_q  <= acc_ena_d;
      end
   end

   // An over-range cycle in TRACK goes to HOLD and skips any window wrap.
   assign lock_en  = (state_q == ST_TRACK) && !ovr_q;
   assign lock_clr = start || (state_q == ST_IDLE) || (state_q == ST_CLEAR) || (state_q == ST_ACQUIRE);

   dc_lock_det #(
      .DATA_WIDTH (DATA_WIDTH),
      .WIN_LEN    (WIN_LEN),
      .LOCK_TOL   (LOCK_TOL),
      .LOCK_WINS  (LOCK_WINS)
   ) u_lock_det (
      .clk    (clk),
      .rst    (rst),
      .en     (lock_en),
      .clr    (lock_clr),
      .dc_est (dc_est),
      .locked (locked)
   );

   assign k_out    = k_out_q;
   assign acc_sclr = acc_sclr_q;
   assign acc_ena  = acc_ena_q;
   assign state_o  = state_q;
   assign ovr_flag = ovr_flag_q;

endmodule

// File: tb/tb_dc_cal_ctrl.sv
// tb/tb_dc_cal_ctrl.sv - self-checking bench for dc_cal_ctrl
module tb_dc_cal_ctrl;

   localparam int          CLR_CYCLES  = 8;
   localparam int          ACQ_CYCLES  = 4096;
   localparam int          HOLD_CYCLES = 256;
   localparam int          WIN_LEN     = 1024;
   localparam int          LOCK_TOL    = 16;
   localparam int          LOCK_WINS   = 4;
   localparam logic [15:0] K_FAST      = 16'h0800;
   localparam logic [15:0] K_SLOW      = 16'h0085;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] ad_din = '0;
   logic [15:0] dc_est = '0;
   logic [15:0] k_out;
   logic        acc_sclr;
   logic        acc_ena;
   logic [2:0]  state_o;
   logic        ovr_flag;
   logic        locked;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dc_cal_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ad_din   (ad_din),
      .dc_est   (dc_est),
      .k_out    (k_out),
      .acc_sclr (acc_sclr),
      .acc_ena  (acc_ena),
      .state_o  (state_o),
      .ovr_flag (ovr_flag),
      .locked   (locked)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_ok();
      int v;
      v = int'($urandom_range(63998)) - 31999;
      return 16'(v);
   endfunction

   function automatic logic [15:0] rand_ovr();
      int v;
      case ($urandom_range(3))
         0:       v = 32000;
         1:       v = -32768;
         2:       v = int'($urandom_range(32767, 32000));
         default: v = -int'($urandom_range(32768, 32000));
      endcase
      return 16'(v);
   endfunction

   function automatic int jit(input int j);
      return int'($urandom_range(2 * j)) - j;
   endfunction

   // Locked iff the last LOCK_WINS window-to-window deltas (after the seeding
   // wrap) are all within tolerance.
   function automatic bit model_locked(input int wv[$]);
      int n;
      int d;
      n = wv.size();
      if (n - 1 < LOCK_WINS) return 1'b0;
      for (int i = n - LOCK_WINS; i < n; i++) begin
         d = wv[i] - wv[i-1];
         if (d < 0) d = -d;
         if (d > LOCK_TOL) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic enter_track(input string tag);
      ad_din = rand_ok();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < CLR_CYCLES + ACQ_CYCLES; i++) begin
         ad_din = rand_ok();
         step();
      end
      checks++;
      if (state_o !== 3'd3) begin
         errors++;
         $display("FAIL %s_enter_track: state_o=%0d required 3", tag, state_o);
      end
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b0;
      start = 1'b0;
      ad_din = 16'h8000;
      repeat (3) step();
      checks++;
      if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: %0d required 0", state_o); end
      checks++;
      if (acc_sclr !== 1'b1 || acc_ena !== 1'b0) begin
         errors++; $display("FAIL reset_acc: sclr=%0b ena=%0b required 1 0", acc_sclr, acc_ena);
      end
      checks++;
      if (k_out !== K_SLOW) begin errors++; $display("FAIL reset_k: %h required %h", k_out, K_SLOW); end
      checks++;
      if (locked !== 1'b0 || ovr_flag !== 1'b0) begin
         errors++; $display("FAIL reset_flags: locked=%0b ovr=%0b required 0 0", locked, ovr_flag);
      end
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         ad_din = ($urandom_range(1) == 1) ? rand_ovr() : rand_ok();
         step();
         if (state_o !== 3'd0 || acc_sclr !== 1'b1 || acc_ena !== 1'b0 || ovr_flag !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL idle_hold: %0d bad cycles required 0", bad); end
   endtask

   task automatic test_sequence();
      int n_clr, n_acq, bad, ovr_at;
      n_clr = 0;
      n_acq = 0;
      bad = 0;
      ovr_at = int'($urandom_range(ACQ_CYCLES - 10, 1));
      ad_din = rand_ok();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < CLR_CYCLES + ACQ_CYCLES + 20 && state_o !== 3'd3; i++) begin
         if (state_o === 3'd1) begin
            n_clr++;
            if (acc_sclr !== 1'b1 || acc_ena !== 1'b1 || k_out !== K_FAST) bad++;
         end else if (state_o === 3'd2) begin
            n_acq++;
            if (acc_sclr !== 1'b0 || acc_ena !== 1'b1 || k_out !== K_FAST) bad++;
         end else begin
            bad++;
         end
         ad_din = (state_o === 3'd2 && n_acq == ovr_at) ? rand_ovr() : rand_ok();
         step();
      end
      checks++;
      if (state_o !== 3'd3) begin errors++; $display("FAIL seq_track: state_o=%0d required 3", state_o); end
      checks++;
      if (n_clr != CLR_CYCLES) begin errors++; $display("FAIL seq_clear_len: %0d required %0d", n_clr, CLR_CYCLES); end
      checks++;
      if (n_acq != ACQ_CYCLES) begin errors++; $display("FAIL seq_acq_len: %0d required %0d", n_acq, ACQ_CYCLES); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL seq_outputs: %0d bad cycles required 0", bad); end
      checks++;
      if (k_out !== K_SLOW || acc_ena !== 1'b1 || acc_sclr !== 1'b0) begin
         errors++; $display("FAIL seq_track_out: k=%h ena=%0b sclr=%0b required %h 1 0", k_out, acc_ena, acc_sclr, K_SLOW);
      end
      checks++;
      if (ovr_flag !== 1'b1) begin errors++; $display("FAIL seq_acq_ovr_flag: %0b required 1", ovr_flag); end
   endtask

   task automatic test_lock();
      int wv[$];
      int base, v, mid_bad;
      bit exp_l;
      enter_track("lock");
      exp_l = 1'b0;
      mid_bad = 0;
      base = 500;
      for (int w = 1; w <= 15; w++) begin
         if (w == 7) base = 600;
         else if (w == 9 || w == 10) base = base + jit(40);
         for (int c = 1; c <= WIN_LEN; c++) begin
            v = (w <= 8) ? base + jit(8) : base;
            dc_est = 16'(v);
            ad_din = rand_ok();
            if (c == WIN_LEN) wv.push_back(v);
            step();
            if (c < WIN_LEN) begin
               if (locked !== exp_l) mid_bad++;
            end else begin
               exp_l = model_locked(wv);
               checks++;
               if (locked !== exp_l) begin
                  errors++; $display("FAIL lock_wrap%0d: locked=%0b required %0b", w, locked, exp_l);
               end
            end
         end
         if (w == 5) begin
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL lock_5th_wrap: %0b required 1", locked); end
         end
         if (w == 7) begin
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL lock_step_unlock: %0b required 0", locked); end
         end
      end
      checks++;
      if (mid_bad != 0) begin errors++; $display("FAIL lock_mid_window: %0d bad cycles required 0", mid_bad); end
   endtask

   // Continues from test_lock: TRACK, locked, dc_est held constant.
   task automatic test_ovr_hold();
      int s[3];
      int n, bad_state, bad_ena, bad_flag, bad_lock, n_frozen, exp_frozen;
      bit in_hold, ovr_seen;
      s[0] = 10 + int'($urandom_range(5));
      s[1] = s[0] + 100;
      s[2] = s[1] + HOLD_CYCLES + int'($urandom_range(30, 0));
      n = s[2] + HOLD_CYCLES + 20;
      bad_state = 0; bad_ena = 0; bad_flag = 0; bad_lock = 0; n_frozen = 0;
      ovr_seen = 1'b0;
      for (int t = 1; t <= n; t++) begin
         if (t == s[0] || t == s[1] || t == s[2]) ad_din = rand_ovr();
         else if ($urandom_range(3) == 0) ad_din = ($urandom_range(1) == 1) ? 16'd31999 : 16'hFFFF - 16'd31998;
         else ad_din = rand_ok();
         step();
         in_hold = 1'b0;
         for (int k = 0; k < 3; k++)
            if (t >= s[k] + 1 && t <= s[k] + HOLD_CYCLES) in_hold = 1'b1;
         if (t >= s[0] + 1) ovr_seen = 1'b1;
         if (state_o !== (in_hold ? 3'd4 : 3'd3)) bad_state++;
         if (acc_ena !== !in_hold || k_out !== K_SLOW || acc_sclr !== 1'b0) bad_ena++;
         if (ovr_flag !== ovr_seen) bad_flag++;
         if (locked !== 1'b1) bad_lock++;
         if (acc_ena === 1'b0) n_frozen++;
      end
      exp_frozen = (s[1] - s[0]) + 2 * HOLD_CYCLES;
      checks++;
      if (bad_state != 0) begin errors++; $display("FAIL hold_state: %0d bad cycles required 0", bad_state); end
      checks++;
      if (bad_ena != 0) begin errors++; $display("FAIL hold_outputs: %0d bad cycles required 0", bad_ena); end
      checks++;
      if (bad_flag != 0) begin errors++; $display("FAIL hold_ovr_flag: %0d bad cycles required 0", bad_flag); end
      checks++;
      if (bad_lock != 0) begin errors++; $display("FAIL hold_locked_kept: %0d bad cycles required 0", bad_lock); end
      checks++;
      if (n_frozen != exp_frozen) begin errors++; $display("FAIL hold_frozen_len: %0d required %0d", n_frozen, exp_frozen); end
   endtask

   // Continues from test_ovr_hold: TRACK, locked=1, ovr_flag=1.
   task automatic test_priority();
      ad_din = 16'h8000;
      step();
      step();
      checks++;
      if (state_o !== 3'd4 || locked !== 1'b1) begin
         errors++; $display("FAIL prio_in_hold: state=%0d locked=%0b required 4 1", state_o, locked);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (state_o !== 3'd1 || acc_sclr !== 1'b1 || k_out !== K_FAST) begin
         errors++; $display("FAIL prio_start_hold: state=%0d sclr=%0b k=%h required 1 1 %h", state_o, acc_sclr, k_out, K_FAST);
      end
      checks++;
      if (ovr_flag !== 1'b0 || locked !== 1'b0) begin
         errors++; $display("FAIL prio_start_clears: ovr=%0b locked=%0b required 0 0", ovr_flag, locked);
      end
      step();
      checks++;
      if (ovr_flag !== 1'b1 || state_o !== 3'd1) begin
         errors++; $display("FAIL prio_ovr_in_clear: ovr=%0b state=%0d required 1 1", ovr_flag, state_o);
      end
      rst = 1'b0;
      start = 1'b1;
      step();
      step();
      checks++;
      if (state_o !== 3'd0 || acc_sclr !== 1'b1 || acc_ena !== 1'b0 || k_out !== K_SLOW || ovr_flag !== 1'b0) begin
         errors++; $display("FAIL prio_rst_over_start: state=%0d sclr=%0b ena=%0b k=%h ovr=%0b required 0 1 0 %h 0",
                            state_o, acc_sclr, acc_ena, k_out, ovr_flag, K_SLOW);
      end
      rst = 1'b1;
      start = 1'b0;
      ad_din = rand_ok();
      repeat (5) step();
      checks++;
      if (state_o !== 3'd0 || acc_sclr !== 1'b1 || acc_ena !== 1'b0) begin
         errors++; $display("FAIL prio_idle_after_rst: state=%0d sclr=%0b ena=%0b required 0 1 0", state_o, acc_sclr, acc_ena);
      end
   endtask

   task automatic test_abs_extreme();
      int wv[$];
      int v;
      bit exp_l;
      enter_track("abs");
      for (int w = 1; w <= 6; w++) begin
         v = (w % 2 == 1) ? 32767 : -32768;
         dc_est = 16'(v);
         wv.push_back(v);
         for (int c = 1; c <= WIN_LEN; c++) begin
            ad_din = rand_ok();
            step();
         end
         exp_l = model_locked(wv);
         checks++;
         if (locked !== exp_l) begin
            errors++; $display("FAIL abs_extreme_wrap%0d: locked=%0b required %0b", w, locked, exp_l);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_lock();
      test_ovr_hold();
      test_priority();
      test_abs_extreme();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
